fillscreen_sweep: RTL and testbench
===================================

// Module: fillscreen_sweep
// PURPOSE
//  Pixel generator that paints the full 160x120 VGA framebuffer with vertical colour stripes.
//  Sits directly upstream of the VGA adapter, and is the block the top-level fill monitor checks.
//  Drives one pixel per clock in column-major order with colour = x mod 8.
//  Raises done once every pixel has been written exactly once.
// PARAMETERS
//  SCREEN_W  160  number of columns; x range 0..SCREEN_W-1 (must fit in 8 bits)
//  SCREEN_H  120  number of rows; y range 0..SCREEN_H-1 (must fit in 7 bits)
// PORTS
//  clk         in   1  system clock (CLOCK_50 at top level)
//  rst_n       in   1  asynchronous active-low reset (KEY[0] at top level)
//  start       in   1  level request; a fill begins when start=1 is sampled in IDLE
//  colour      in   3  unused by this block (kept for the lab's shared interface); must be ignored
//  done        out  1  high when the fill is complete; drives LEDR[0]
//  vga_x       out  8  pixel column
//  vga_y       out  7  pixel row
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  write strobe; the adapter samples x/y/colour on the rising clk edge when this is 1
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; done, vga_plot, vga_x, vga_y and vga_colour all 0.
//   - Takes effect immediately, including mid-fill. No partial state survives.
//  FSM: IDLE -> FILL -> DONE -> IDLE
//   - IDLE: vga_plot=0, done=0, counters held at (0,0). Goes to FILL on the edge where start=1.
//   - FILL: vga_plot=1 on every cycle; {vga_x,vga_y} is the current pixel.
//     - If y < SCREEN_H-1: y <= y+1.
//     - Else: y <= 0 and x <= x+1.
//     - On the cycle that presents (SCREEN_W-1, SCREEN_H-1), next state is DONE.
//   - DONE: done=1, vga_plot=0, counters reset to (0,0).
//     - Stays in DONE while start=1.
//     - Goes to IDLE on the edge where start=0; done falls in that same cycle.
//  Ordering: (0,0),(0,1)..(0,119),(1,0)..(159,119).
//   - Each pixel is plotted exactly once per fill; no duplicates.
//   - No coordinate outside range is ever presented with vga_plot=1.
//  Colour: vga_colour = vga_x[2:0] whenever vga_plot=1, so the pattern repeats every 8 columns.
//  Latency, with start sampled at edge 0:
//   - Pixel (0,0) is presented in cycle 1.
//   - Pixel (159,119) is presented in cycle 19200.
//   - done=1 from cycle 19201, which is within the 19210-cycle budget.
//  All outputs come from registers or state decode only; no combinational path from start to outputs.
//  Start deasserted during FILL: ignored; the fill runs to completion.
//  Start held continuously after DONE: no re-fill. A new fill needs start to drop and rise again.
//  Counter widths:
//   - x is 8-bit and y is 7-bit.
//   - The terminal compare uses SCREEN_W-1 / SCREEN_H-1, never a natural overflow.
// TESTING
//  T1 Reset:
//   - Stimulus: rst_n=0 with start=1.
//   - Required: done=0, vga_plot=0, x=y=0, and no plot until rst_n=1 plus one edge with start=1.
//  T2 Full fill:
//   - Stimulus: start=1 held.
//   - Required: exactly 19200 plots; every (x,y) appears once; colour == x%8; done=1 at cycle 19201.
//  T3 Wrap:
//   - Required sequence: (0,119) then (1,0).
//   - Required: (7,*) has colour 7 and (8,*) has colour 0.
//   - Required: (159,119) is the last plot and vga_plot=0 on the next cycle.
//  T4 Start dropped mid-fill:
//   - Stimulus: start=0 at cycle 5000.
//   - Required: the fill still completes at (159,119); done pulses one cycle, then IDLE.
//  T5 Reset mid-fill:
//   - Stimulus: rst_n=0 at cycle 9000, then restart.
//   - Required: outputs go to 0 immediately; the new fill begins at (0,0) with no duplicate warnings after the monitor clears.
//  T6 Re-trigger:
//   - Stimulus: start 1 -> 0 -> 1 after done.
//   - Required: a second full fill, identical to T2.

Source files
------------

// File: rtl/fillscreen_sweep.sv
// Full-screen pixel sweep: paints the framebuffer column-major
// with vertical colour stripes (colour = x mod 8), then raises done.
module fillscreen_sweep #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] x;
    logic [7:0] x_next;
    logic [6:0] y;
    logic [6:0] y_next;
    logic       last_px;

    // The colour input is part of the shared lab interface only.
    logic       colour_unused;
    assign colour_unused = ^colour;

    assign last_px = (x == X_LAST) && (y == Y_LAST);

    // State and pixel counters; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= 8'd0;
            y     <= 7'd0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
        end
    end

    // Next state and counter advance; counters sit at (0,0) outside FILL.
    always_comb begin
        state_next = state;
        x_next     = 8'd0;
        y_next     = 7'd0;
        unique case (state)
            IDLE: begin
                if (start) state_next = FILL;
            end
            FILL: begin
                if (last_px) begin
                    state_next = DONE;
                end else if (y == Y_LAST) begin
                    x_next = x + 8'd1;
                    y_next = 7'd0;
                end else begin
                    x_next = x;
                    y_next = y + 7'd1;
                end
            end
            DONE: begin
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign vga_plot   = (state == FILL);
    assign done       = (state == DONE);
    assign vga_x      = x;
    assign vga_y      = y;
    assign vga_colour = vga_plot ? x[2:0] : 3'd0;

endmodule

// File: tb/tb_fillscreen_sweep.sv
// Directed bench for fillscreen_sweep: reset, full fill, wrap,
// start drop, reset mid-fill and re-trigger scenarios.
module tb_fillscreen_sweep;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int NPIX  = W * H;
    localparam int BUDGET = 19210;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int vectors;
    int miscompares;

    fillscreen_sweep #(
        .SCREEN_W(W),
        .SCREEN_H(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .colour    (colour),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one fill from IDLE; start rises before edge 0, cycle k sampled
    // at the negedge after edge k-1. Returns statistics gathered on the way.
    task automatic run_fill(
        input  int          drop_at,
        output int          plots,
        output int          order_err,
        output int          dup_err,
        output int          col_err,
        output int          done_cyc,
        output int          last_k,
        output logic [14:0] last_xy,
        output logic [14:0] xy119,
        output logic [14:0] xy120,
        output logic [2:0]  c7,
        output logic [2:0]  c8
    );
        bit seen [W][H];
        int ex;
        int ey;
        plots     = 0;
        order_err = 0;
        dup_err   = 0;
        col_err   = 0;
        done_cyc  = 0;
        last_k    = 0;
        last_xy   = '0;
        xy119     = '1;
        xy120     = '1;
        c7        = 3'bxxx;
        c8        = 3'bxxx;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                seen[i][j] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (vga_plot === 1'b1) begin
                ex = plots / H;
                ey = plots % H;
                if (vga_x !== 8'(ex) || vga_y !== 7'(ey))
                    order_err++;
                if (int'(vga_x) < W && int'(vga_y) < H) begin
                    if (seen[vga_x][vga_y]) dup_err++;
                    seen[vga_x][vga_y] = 1'b1;
                end else begin
                    order_err++;
                end
                if (vga_colour !== 3'(ex % 8)) col_err++;
                if (plots == 119) xy119 = {vga_x, vga_y};
                if (plots == 120) xy120 = {vga_x, vga_y};
                if (plots == 7 * H) c7 = vga_colour;
                if (plots == 8 * H) c8 = vga_colour;
                last_k  = k;
                last_xy = {vga_x, vga_y};
                plots++;
            end
            if (k == drop_at) start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad    = 0;
        colour = 3'd5;
        start  = 1'b1;
        rst_n  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if ({done, vga_plot, vga_x, vga_y, vga_colour} !== 20'd0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs: %0d nonzero samples, required 0", bad);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({done, vga_plot, vga_x, vga_y} !== 17'd0) begin
            miscompares++;
            $display("FAIL idle_no_plot: done=%b plot=%b x=%0d y=%0d, required 0",
                     done, vga_plot, vga_x, vga_y);
        end
    endtask

    task automatic test_full_fill();
        int plots, oerr, derr, cerr, dcyc, lk;
        logic [14:0] lxy, a, b;
        logic [2:0]  c7, c8;
        run_fill(0, plots, oerr, derr, cerr, dcyc, lk, lxy, a, b, c7, c8);
        vectors++;
        if (plots !== NPIX) begin
            miscompares++;
            $display("FAIL fill_count: got %0d plots, required %0d", plots, NPIX);
        end
        vectors++;
        if (oerr !== 0) begin
            miscompares++;
            $display("FAIL fill_order: %0d out-of-order plots, required 0", oerr);
        end
        vectors++;
        if (derr !== 0) begin
            miscompares++;
            $display("FAIL fill_dup: %0d duplicates, required 0", derr);
        end
        vectors++;
        if (cerr !== 0) begin
            miscompares++;
            $display("FAIL fill_colour: %0d bad colours, required 0", cerr);
        end
        vectors++;
        if (dcyc !== 19201) begin
            miscompares++;
            $display("FAIL done_cycle: got %0d, required 19201", dcyc);
        end
        vectors++;
        if (a !== {8'd0, 7'd119} || b !== {8'd1, 7'd0}) begin
            miscompares++;
            $display("FAIL wrap_seq: got %h then %h, required %h then %h",
                     a, b, {8'd0, 7'd119}, {8'd1, 7'd0});
        end
        vectors++;
        if (c7 !== 3'd7 || c8 !== 3'd0) begin
            miscompares++;
            $display("FAIL stripe_colour: col7=%0d col8=%0d, required 7 and 0", c7, c8);
        end
        vectors++;
        if (lk !== 19200 || lxy !== {8'd159, 7'd119}) begin
            miscompares++;
            $display("FAIL last_plot: cycle %0d xy %h, required 19200 xy %h",
                     lk, lxy, {8'd159, 7'd119});
        end
        vectors++;
        if (vga_plot !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
            miscompares++;
            $display("FAIL done_idle_outs: plot=%b x=%0d y=%0d, required 0 0 0",
                     vga_plot, vga_x, vga_y);
        end
    endtask

    task automatic test_hold_no_refill();
        int bad;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL hold_done: %0d bad samples, required 0", bad);
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || vga_plot !== 1'b0) begin
            miscompares++;
            $display("FAIL done_fall: done=%b plot=%b, required 0 0", done, vga_plot);
        end
    endtask

    task automatic test_retrigger_start_drop();
        int plots, oerr, derr, cerr, dcyc, lk;
        logic [14:0] lxy, a, b;
        logic [2:0]  c7, c8;
        run_fill(5000, plots, oerr, derr, cerr, dcyc, lk, lxy, a, b, c7, c8);
        vectors++;
        if (plots !== NPIX || oerr !== 0 || derr !== 0 || cerr !== 0) begin
            miscompares++;
            $display("FAIL refill: plots=%0d order=%0d dup=%0d col=%0d, required %0d 0 0 0",
                     plots, oerr, derr, cerr, NPIX);
        end
        vectors++;
        if (lxy !== {8'd159, 7'd119} || dcyc !== 19201) begin
            miscompares++;
            $display("FAIL drop_complete: last %h done@%0d, required %h done@19201",
                     lxy, dcyc, {8'd159, 7'd119});
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || vga_plot !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b plot=%b, required 0 0", done, vga_plot);
        end
    endtask

    task automatic test_reset_mid_fill();
        int plots, oerr, derr, cerr, dcyc, lk;
        logic [14:0] lxy, a, b;
        logic [2:0]  c7, c8;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (9000) @(negedge clk);
        vectors++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd74 || vga_y !== 7'd119) begin
            miscompares++;
            $display("FAIL mid_fill_pos: plot=%b x=%0d y=%0d, required 1 74 119",
                     vga_plot, vga_x, vga_y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({done, vga_plot, vga_x, vga_y, vga_colour} !== 20'd0) begin
            miscompares++;
            $display("FAIL async_reset: done=%b plot=%b x=%0d y=%0d c=%0d, required 0",
                     done, vga_plot, vga_x, vga_y, vga_colour);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_fill(0, plots, oerr, derr, cerr, dcyc, lk, lxy, a, b, c7, c8);
        vectors++;
        if (plots !== NPIX || oerr !== 0 || derr !== 0 || dcyc !== 19201) begin
            miscompares++;
            $display("FAIL restart_fill: plots=%0d order=%0d dup=%0d done@%0d, required %0d 0 0 19201",
                     plots, oerr, derr, dcyc, NPIX);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        colour      = 3'd0;
        test_reset();
        test_full_fill();
        test_hold_no_refill();
        test_retrigger_start_drop();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
